// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Load-use / taken-branch / multi-cycle MUL-DIV stall sequencer
//            for the 5-stage core. Optional stall counter: HAZARD_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int TMO_W      = 7,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             IF_ID_UsesRs2,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_MulDiv,
    input  logic             Branch_Taken,
    input  logic             MD_Done,
    output logic             MD_Start,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             MD_Error,
    output logic [CNT_W-1:0] Stall_Count
);

    localparam logic [0:0]       c_ST_RUN     = 1'b0;
    localparam logic [0:0]       c_ST_MD_WAIT = 1'b1;
    localparam logic [TMO_W-1:0] c_WDOG_LAST  = TMO_W'(MD_TIMEOUT - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [TMO_W-1:0] r_wdog;
    logic [TMO_W-1:0] w_wdog_nxt;
    logic             r_md_error;
    logic             w_md_error_nxt;
    logic             w_load_use;

    assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                        ((ID_EX_Rd == IF_ID_Rs1) ||
                         (IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_RUN;
            r_wdog     <= '0;
            r_md_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wdog     <= w_wdog_nxt;
            r_md_error <= w_md_error_nxt;
        end
    end

    // Outputs are decoded in the same cycle; while reset is high they are
    // forced to the free-running defaults so an aborted wait releases at once.
    always_comb begin
        MD_Start       = 1'b0;
        PC_Write       = 1'b1;
        IF_ID_Write    = 1'b1;
        IF_ID_Flush    = 1'b0;
        ID_EX_Write    = 1'b1;
        ID_EX_Flush    = 1'b0;
        EX_MEM_Flush   = 1'b0;
        w_state_nxt    = r_state;
        w_wdog_nxt     = r_wdog;
        w_md_error_nxt = r_md_error;
        if (!reset) begin
            case (r_state)
                c_ST_RUN: begin
                    w_wdog_nxt = '0;
                    if (Branch_Taken) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (ID_EX_MulDiv) begin
                        MD_Start     = 1'b1;
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        w_state_nxt  = c_ST_MD_WAIT;
                    end else if (w_load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                c_ST_MD_WAIT: begin
                    if (MD_Done) begin
                        w_state_nxt = c_ST_RUN;
                        w_wdog_nxt  = '0;
                    end else if (r_wdog >= c_WDOG_LAST) begin
                        w_state_nxt    = c_ST_RUN;
                        w_wdog_nxt     = '0;
                        w_md_error_nxt = 1'b1;
                    end else begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        w_wdog_nxt   = r_wdog + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_RUN;
                    w_wdog_nxt  = '0;
                end
            endcase
        end
    end

    assign MD_Error = r_md_error;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating: a long-running count must never wrap back to a small value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!PC_Write && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign Stall_Count = r_stall_cnt;
`else
    assign Stall_Count = '0;
`endif

endmodule
`default_nettype wire
